retrigger_oneshot: RTL and testbench

RETRIGGER_ONESHOT -- requirements
Module: retrigger_oneshot

---
 rtl/retrigger_oneshot.sv | 183 ++++++++++++++++++
 tb/tb_retrigger_oneshot.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/retrigger_oneshot.sv
// retrigger_oneshot
//   Bank of WIDTH independent retriggerable one-shots with active-low outputs.
//   Each channel detects a rising edge on its trigger input. On an armed edge it
//   drives q low for max(width_cfg,1) cycles. It then optionally holds q high
//   for a dead time of dead_cfg cycles, during which further edges are dropped.
//   A lost trigger latches a sticky 'missed' flag.
//
//   Build option:
//     RETRIG_SYNC_EN - inserts a two-flop synchronizer ahead of the input
//                      register stage, adding two cycles of trigger latency.
//
//   Ports:
//     clk          clock; all state changes on its rising edge
//     rst          asynchronous active-high reset
//     pulse        per-channel trigger inputs
//     act          per-channel arm (1 = armed)
//     width_cfg    pulse length in cycles (0 behaves as 1), sampled at load
//     dead_cfg     dead time in cycles (0 = no dead time), sampled at entry
//     retrig_mode  1 = an edge while active restarts the pulse
//     clr_missed   synchronous clear of all missed flags (a same-cycle set wins)
//     q            active-low one-shot outputs, idle high
//     missed       sticky lost-trigger flags
//     state_dbg    per-channel FSM state, 2 bits per channel (0 idle, 1 active, 2 dead)
//
//   There are no valid/ready handshakes on this block. All inputs are level
//   signals that are sampled on every clock.
module retrigger_oneshot #(
  parameter int WIDTH = 48,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [WIDTH-1:0]     pulse,
  input  logic [WIDTH-1:0]     act,
  input  logic [CNT_W-1:0]     width_cfg,
  input  logic [CNT_W-1:0]     dead_cfg,
  input  logic                 retrig_mode,
  input  logic                 clr_missed,
  output logic [WIDTH-1:0]     q,
  output logic [WIDTH-1:0]     missed,
  output logic [2*WIDTH-1:0]   state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACTIVE = 2'd1,
    S_DEAD   = 2'd2
  } state_t;

  state_t           state [WIDTH];
  logic [CNT_W-1:0] cnt   [WIDTH];

  logic [WIDTH-1:0] pulse_in;
  logic [WIDTH-1:0] pulse_r;
  logic [WIDTH-1:0] pulse_d;
  logic [WIDTH-1:0] trig;
  logic [WIDTH-1:0] miss_set;
  logic [CNT_W-1:0] width_load;

`ifdef RETRIG_SYNC_EN
  logic [WIDTH-1:0] sync1;
  logic [WIDTH-1:0] sync2;

  // Reset to 1 so that a line held high through reset does not look like a rising edge.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '1;
      sync2 <= '1;
    end else begin
      sync1 <= pulse;
      sync2 <= sync1;
    end
  end

  assign pulse_in = sync2;
`else
  assign pulse_in = pulse;
`endif

  // The edge detector also resets to 1 for the same reason.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pulse_r <= '1;
      pulse_d <= '1;
    end else begin
      pulse_r <= pulse_in;
      pulse_d <= pulse_r;
    end
  end

  assign trig       = pulse_r & ~pulse_d;
  assign width_load = (width_cfg == '0) ? CNT_W'(1) : width_cfg;

  // Lost-trigger events are only counted while the channel is armed. An edge
  // that arrives in the same cycle as a transition is judged against the
  // state before that transition.
  always_comb begin
    miss_set = '0;
    for (int i = 0; i < WIDTH; i++) begin
      if (trig[i] && act[i]) begin
        if ((state[i] == S_ACTIVE && !retrig_mode) || state[i] == S_DEAD) begin
          miss_set[i] = 1'b1;
        end
      end
    end
  end

  // Sticky flags: the clear is applied first, then new sets are ORed in, so a set wins.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      missed <= '0;
    end else begin
      missed <= (missed & ~{WIDTH{clr_missed}}) | miss_set;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '1;
      for (int i = 0; i < WIDTH; i++) begin
        state[i] <= S_IDLE;
        cnt[i]   <= '0;
      end
    end else begin
      for (int i = 0; i < WIDTH; i++) begin
        case (state[i])
          S_IDLE: begin
            if (trig[i] && act[i]) begin
              state[i] <= S_ACTIVE;
              cnt[i]   <= width_load;
              q[i]     <= 1'b0;
            end
          end

          S_ACTIVE: begin
            if (!act[i]) begin
              state[i] <= S_IDLE;
              cnt[i]   <= '0;
              q[i]     <= 1'b1;
            end else if (trig[i] && retrig_mode) begin
              // Restart the count. q is already low, so no high glitch can occur.
              cnt[i] <= width_load;
            end else if (cnt[i] <= CNT_W'(1)) begin
              q[i] <= 1'b1;
              if (dead_cfg == '0) begin
                state[i] <= S_IDLE;
                cnt[i]   <= '0;
              end else begin
                state[i] <= S_DEAD;
                cnt[i]   <= dead_cfg;
              end
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end

          S_DEAD: begin
            if (!act[i] || cnt[i] <= CNT_W'(1)) begin
              state[i] <= S_IDLE;
              cnt[i]   <= '0;
            end else begin
              cnt[i] <= cnt[i] - CNT_W'(1);
            end
          end

          default: begin
            state[i] <= S_IDLE;
            cnt[i]   <= '0;
            q[i]     <= 1'b1;
          end
        endcase
      end
    end
  end

  always_comb begin
    state_dbg = '0;
    for (int i = 0; i < WIDTH; i++) begin
      state_dbg[2*i +: 2] = state[i];
    end
  end

endmodule

// File: tb/tb_retrigger_oneshot.sv
// tb_retrigger_oneshot
//   Directed bench for a 4-channel retrigger_oneshot. The driver applies inputs
//   on falling edges and pushes the expected {cycle, q, missed} for every cycle
//   it cares about. The monitor samples 1 time unit after each rising edge and
//   checks each entry whose cycle has been reached.
module tb_retrigger_oneshot;

  localparam int WIDTH = 4;
  localparam int CNT_W = 8;
  localparam int EW    = 40;
`ifdef RETRIG_SYNC_EN
  localparam int LAT   = 4;
`else
  localparam int LAT   = 2;
`endif

  logic               clk;
  logic               rst;
  logic [WIDTH-1:0]   pulse;
  logic [WIDTH-1:0]   act;
  logic [CNT_W-1:0]   width_cfg;
  logic [CNT_W-1:0]   dead_cfg;
  logic               retrig_mode;
  logic               clr_missed;
  logic [WIDTH-1:0]   q;
  logic [WIDTH-1:0]   missed;
  logic [2*WIDTH-1:0] state_dbg;

  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] ent;
  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int t;
  int p;

  retrigger_oneshot #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .pulse(pulse), .act(act),
    .width_cfg(width_cfg), .dead_cfg(dead_cfg), .retrig_mode(retrig_mode),
    .clr_missed(clr_missed), .q(q), .missed(missed), .state_dbg(state_dbg)
  );

  // clock / cycle counter
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // monitor / scoreboard
  always @(posedge clk) begin
    #1;
    while (exp_q.size() > 0 && exp_q[0][39:8] <= 32'(cyc)) begin
      ent = exp_q.pop_front();
      total++;
      if (ent[39:8] != 32'(cyc)) begin
        bad++;
        $display("FAIL sched: entry for cycle %0d seen at cycle %0d", ent[39:8], cyc);
      end else if (q !== ent[7:4] || missed !== ent[3:0]) begin
        bad++;
        $display("FAIL cyc%0d: q=%b missed=%b expected q=%b missed=%b",
                 cyc, q, missed, ent[7:4], ent[3:0]);
      end
    end
  end

  // driver tasks
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask

  // Expect q low on the channels in 'mask' during cycles [lo_from, lo_to], and
  // high everywhere else in [from, to]. 'mv' is the expected missed value.
  task automatic push_window(input int from, input int to, input int lo_from,
                             input int lo_to, input logic [3:0] mask,
                             input logic [3:0] mv);
    for (int c = from; c <= to; c++) begin
      exp_q.push_back({32'(c), ((c >= lo_from && c <= lo_to) ? ~mask : 4'hF), mv});
    end
  endtask

  task automatic chk(input string name, input logic [31:0] actual, input logic [31:0] expv);
    total++;
    if (actual !== expv) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, actual, expv);
    end
  endtask

  task automatic clear_missed_flags();
    int tc;
    tc = cyc;
    clr_missed = 1'b1;
    push_window(tc + 1, tc + 2, 1, 0, 4'b0000, 4'b0000);
    step(1);
    clr_missed = 1'b0;
    step(2);
  endtask

  // stimulus
  initial begin
    rst = 1'b1; pulse = 4'b1000; act = 4'hF; width_cfg = 8'd5; dead_cfg = 8'd0;
    retrig_mode = 1'b1; clr_missed = 1'b0;
    step(3);
    chk("reset_q", 32'(q), 32'hF);
    chk("reset_missed", 32'(missed), 32'h0);
    chk("reset_state", 32'(state_dbg), 32'h0);

    // pulse[3] is held high through the reset release and must not trigger
    rst = 1'b0;
    t = cyc;
    push_window(t + 1, t + 8, 1, 0, 4'b0000, 4'b0000);
    step(3);
    pulse = 4'b0000;
    step(6);

    // 5-cycle pulse on channel 0; width_cfg changes mid-pulse and must not shorten it
    t = cyc; p = t + LAT;
    pulse[0] = 1'b1;
    push_window(t + 1, p + 6, p, p + 4, 4'b0001, 4'b0000);
    for (int k = 1; k <= LAT + 7; k++) begin
      step(1);
      if (k >= LAT) width_cfg = 8'd1;
    end
    pulse[0] = 1'b0;
    step(3);

    // retrigger: second edge 6 cycles later gives a continuous 16-cycle low
    width_cfg = 8'd10; retrig_mode = 1'b1;
    t = cyc; p = t + LAT;
    pulse[0] = 1'b1;
    push_window(t + 1, p + 17, p, p + 15, 4'b0001, 4'b0000);
    for (int k = 1; k <= LAT + 18; k++) begin
      step(1);
      pulse[0] = (k == 6);
    end

    // non-extending: 10-cycle low; the second edge sets missed[0]
    retrig_mode = 1'b0;
    t = cyc; p = t + LAT;
    pulse[0] = 1'b1;
    push_window(t + 1, p + 5, p, p + 9, 4'b0001, 4'b0000);
    push_window(p + 6, p + 12, p, p + 9, 4'b0001, 4'b0001);
    for (int k = 1; k <= LAT + 13; k++) begin
      step(1);
      pulse[0] = (k == 6);
    end
    clear_missed_flags();

    // dead time: an edge in DEAD is dropped and sets missed, and the set wins
    // over a clear in the same cycle; an edge one cycle after DEAD ends fires
    // a new 3-cycle pulse
    retrig_mode = 1'b1; width_cfg = 8'd3; dead_cfg = 8'd4;
    t = cyc; p = t + LAT;
    pulse[0] = 1'b1;
    push_window(t + 1, p + 3, p, p + 2, 4'b0001, 4'b0000);
    push_window(p + 4, p + 15, p + 8, p + 10, 4'b0001, 4'b0001);
    for (int k = 1; k <= LAT + 16; k++) begin
      step(1);
      pulse[0]   = (k == 4 || k == 8);
      clr_missed = (k == LAT + 3);
    end
    clear_missed_flags();

    // width_cfg=0 gives 1 cycle; a disarmed channel 1 ignores its edge
    width_cfg = 8'd0; dead_cfg = 8'd0; act = 4'b1101;
    t = cyc; p = t + LAT;
    pulse = 4'b0011;
    push_window(t + 1, p + 3, p, p, 4'b0001, 4'b0000);
    for (int k = 1; k <= LAT + 4; k++) begin
      step(1);
      pulse = 4'b0000;
    end

    // act dropped mid-pulse on channel 2 -> q high the next cycle
    act = 4'hF; width_cfg = 8'd8;
    t = cyc; p = t + LAT;
    pulse[2] = 1'b1;
    push_window(t + 1, p + 5, p, p + 2, 4'b0100, 4'b0000);
    for (int k = 1; k <= LAT + 6; k++) begin
      step(1);
      pulse[2] = 1'b0;
      act = (k >= LAT + 2) ? 4'b1011 : 4'hF;
    end
    act = 4'hF;
    step(2);

    // reset asserted mid-pulse forces q high without a clock edge
    width_cfg = 8'd10;
    t = cyc; p = t + LAT;
    pulse[0] = 1'b1;
    push_window(t + 1, p + 1, p, p + 9, 4'b0001, 4'b0000);
    while (cyc < p + 2) step(1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_reset_q", 32'(q), 32'hF);
    chk("async_reset_missed", 32'(missed), 32'h0);
    step(2);
    rst = 1'b0;
    t = cyc;
    push_window(t + 1, t + 6, 1, 0, 4'b0000, 4'b0000);
    step(7);
    pulse = 4'b0000;
    step(2);

    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
